hlr_bm1_err_monitor: RTL and testbench
======================================

Name: hlr_bm1_err_monitor

Overview:
- Registered pair of 8-bit signed multipliers: exact two's-complement product, and an approximate HLR-BM1 product (hybrid high-radix Booth encoding).
- Per sample, outputs both products and their absolute error.
- Keeps running statistics (error sum, maximum exact product, sample count) so the normalized mean error distance (NMED) can be computed as err_sum / sample_count / max_exact.
- Used in approximate-arithmetic characterization sweeps.

Parameters:
- WIDTH, 8: operand width; only 8 is supported, and the encoding below is fixed for it.
- ACC_W, 32: width of err_sum and sample_count.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  sample strobe
- clear  in  1  synchronous clear of statistics
- x  in  8  signed multiplicand
- y  in  8  signed multiplier (Booth-encoded operand)
- out_valid  out  1  registered in_valid
- prod_exact  out  16  signed x*y
- prod_hlr  out  16  signed approximate product
- abs_err  out  16  |prod_hlr - prod_exact|
- err_sum  out  ACC_W  accumulated abs_err
- max_exact  out  16  signed maximum of prod_exact seen
- sample_count  out  ACC_W  number of accepted samples

Behaviour:
- Reset (asynchronous, rst=1): every output and register is 0, including max_exact.
- Latency 1 cycle. On a clk edge with in_valid=1, the per-sample outputs load from that cycle's x and y and out_valid goes 1. With in_valid=0, out_valid goes 0 and the per-sample outputs hold.
- Exact product: full signed 8x8 -> 16-bit product, no truncation.
- HLR-BM1 encoding of y, bit-level, with y3 = y[3] etc.:
  - d0 = -8*y3 + 4*y2 + 2*y1 + y0, a radix-16 digit in [-8,7].
  - d1 = -2*y5 + y4 + y3 and d2 = -2*y7 + y6 + y5, radix-4 Booth digits in [-2,2].
  - Identity: y = d0 + 16*d1 + 64*d2.
- d0 approximation (symmetric in sign):
  - 0, ±1, ±2, ±4, -8 unchanged.
  - ±3 -> ±4, ±5 -> ±4, ±6 -> ±8, ±7 -> ±8.
- Approximate product: prod_hlr = x*a0 + 16*x*d1 + 64*x*d2, where a0 is the approximated d0.
  - Partial products are formed from shifted and negated x only; no general multiplier is allowed in that path.
  - Sum is in 16-bit two's complement. The result always fits: |y_approx| <= 128 and |x| <= 128.
- Error and statistics:
  - abs_err is the magnitude of the 16-bit signed difference; its maximum is 256.
  - On each accepted sample: err_sum += abs_err of that sample and sample_count += 1.
  - max_exact is replaced when the new prod_exact > max_exact (signed compare).
  - Statistics update in the same edge as the per-sample outputs.
- clear=1 at a clk edge zeroes err_sum, sample_count and max_exact. If in_valid=1 in the same cycle, clear takes priority for the statistics and that sample is not counted; per-sample outputs still load.
- Accumulators wrap modulo 2^ACC_W; no saturation. A full 65536-sample sweep stays at or below 2^24.
- Reset asserted mid-sweep clears everything immediately, independent of clk.

Test Plan:
- x=5, y=3: d0=3 -> 4, so prod_exact=15, prod_hlr=20, abs_err=5, out_valid one cycle after in_valid.
- x=10, y=6 -> exact 60, hlr 80, abs_err 20.
- x=2, y=13 (d0=-3 -> -4, d1=1) -> exact 26, hlr 24, abs_err 2.
- x=-128, y=-128 -> exact 16384, hlr 16384, abs_err 0, max_exact=16384.
- x=7, y=-1 -> both -7, abs_err 0.
- Full sweep of all 65536 (x,y) pairs, then clear:
  - sample_count = 65536, max_exact = 16384, err_sum matches the software model; NMED is computed from these.
  - Asserting rst, or clear, afterwards returns all statistics to 0.

Source files
------------

// File: rtl/hlr_bm1_err_monitor.sv
// Exact and HLR-BM1 approximate 8x8 signed multipliers with per-sample error
// and running statistics (error sum, max exact product, sample count) for NMED.

module hlr_bm1_err_monitor #(
  parameter int WIDTH = 8,
  parameter int ACC_W = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  input  logic                      clear,
  input  logic signed [WIDTH-1:0]   x,
  input  logic signed [WIDTH-1:0]   y,
  output logic                      out_valid,
  output logic signed [2*WIDTH-1:0] prod_exact,
  output logic signed [2*WIDTH-1:0] prod_hlr,
  output logic [2*WIDTH-1:0]        abs_err,
  output logic [ACC_W-1:0]          err_sum,
  output logic signed [2*WIDTH-1:0] max_exact,
  output logic [ACC_W-1:0]          sample_count
);

  localparam int PW = 2 * WIDTH;

  // Radix-16 low digit rounded onto {0, +-1, +-2, +-4, +-8} so it costs one shift.
  function automatic logic signed [4:0] approx_d0(input logic [3:0] nib);
    logic signed [4:0] dig;
    case (nib)
      4'h0:    dig = 5'sd0;
      4'h1:    dig = 5'sd1;
      4'h2:    dig = 5'sd2;
      4'h3:    dig = 5'sd4;
      4'h4:    dig = 5'sd4;
      4'h5:    dig = 5'sd4;
      4'h6:    dig = 5'sd8;
      4'h7:    dig = 5'sd8;
      4'h8:    dig = -5'sd8;
      4'h9:    dig = -5'sd8;
      4'hA:    dig = -5'sd8;
      4'hB:    dig = -5'sd4;
      4'hC:    dig = -5'sd4;
      4'hD:    dig = -5'sd4;
      4'hE:    dig = -5'sd2;
      4'hF:    dig = -5'sd1;
      default: dig = 5'sd0;
    endcase
    return dig;
  endfunction

  function automatic logic signed [4:0] booth4(input logic [2:0] trip);
    logic signed [4:0] dig;
    case (trip)
      3'b000:  dig = 5'sd0;
      3'b001:  dig = 5'sd1;
      3'b010:  dig = 5'sd1;
      3'b011:  dig = 5'sd2;
      3'b100:  dig = -5'sd2;
      3'b101:  dig = -5'sd1;
      3'b110:  dig = -5'sd1;
      3'b111:  dig = 5'sd0;
      default: dig = 5'sd0;
    endcase
    return dig;
  endfunction

  // Partial product for a digit in {0, +-1, +-2, +-4, +-8}: shift, then optionally negate.
  function automatic logic [PW-1:0] scaled_pp(input logic [PW-1:0] xs,
                                              input logic signed [4:0] dig);
    logic [4:0]    mag;
    logic [PW-1:0] sh;
    if (dig[4]) begin
      mag = 5'(-dig);
    end else begin
      mag = 5'(dig);
    end
    case (mag)
      5'd1:    sh = xs;
      5'd2:    sh = {xs[PW-2:0], 1'b0};
      5'd4:    sh = {xs[PW-3:0], 2'b00};
      5'd8:    sh = {xs[PW-4:0], 3'b000};
      default: sh = {PW{1'b0}};
    endcase
    if (dig[4]) begin
      return ~sh + 16'd1;
    end else begin
      return sh;
    end
  endfunction

  logic signed [PW-1:0] x_ext_s;
  logic signed [PW-1:0] y_ext_s;
  logic signed [4:0]    a0_s;
  logic signed [4:0]    d1_s;
  logic signed [4:0]    d2_s;
  logic [PW-1:0]        pp0_s;
  logic [PW-1:0]        pp1_s;
  logic [PW-1:0]        pp2_s;
  logic signed [PW-1:0] exact_s;
  logic signed [PW-1:0] hlr_s;
  logic [PW-1:0]        diff_s;
  logic [PW-1:0]        abs_s;

  logic                 out_valid_q,  out_valid_d;
  logic signed [PW-1:0] prod_exact_q, prod_exact_d;
  logic signed [PW-1:0] prod_hlr_q,   prod_hlr_d;
  logic [PW-1:0]        abs_err_q,    abs_err_d;
  logic [ACC_W-1:0]     err_sum_q,    err_sum_d;
  logic signed [PW-1:0] max_exact_q,  max_exact_d;
  logic [ACC_W-1:0]     count_q,      count_d;

  // Both product datapaths and the error magnitude for the current operands.
  always_comb begin
    x_ext_s = {{(PW-WIDTH){x[WIDTH-1]}}, x};
    y_ext_s = {{(PW-WIDTH){y[WIDTH-1]}}, y};
    exact_s = x_ext_s * y_ext_s;
    a0_s    = approx_d0(y[3:0]);
    d1_s    = booth4(y[5:3]);
    d2_s    = booth4(y[7:5]);
    pp0_s   = scaled_pp(x_ext_s, a0_s);
    pp1_s   = scaled_pp(x_ext_s, d1_s);
    pp2_s   = scaled_pp(x_ext_s, d2_s);
    hlr_s   = pp0_s + {pp1_s[PW-5:0], 4'b0000} + {pp2_s[PW-7:0], 6'b000000};
    diff_s  = hlr_s - exact_s;
    if (diff_s[PW-1]) begin
      abs_s = ~diff_s + 16'd1;
    end else begin
      abs_s = diff_s;
    end
  end

  // Next state: per-sample outputs load on in_valid; clear outranks accumulation.
  always_comb begin
    out_valid_d  = in_valid;
    prod_exact_d = prod_exact_q;
    prod_hlr_d   = prod_hlr_q;
    abs_err_d    = abs_err_q;
    err_sum_d    = err_sum_q;
    max_exact_d  = max_exact_q;
    count_d      = count_q;
    if (in_valid) begin
      prod_exact_d = exact_s;
      prod_hlr_d   = hlr_s;
      abs_err_d    = abs_s;
    end else begin
      prod_exact_d = prod_exact_q;
    end
    if (clear) begin
      err_sum_d   = {ACC_W{1'b0}};
      max_exact_d = {PW{1'b0}};
      count_d     = {ACC_W{1'b0}};
    end else if (in_valid) begin
      err_sum_d = err_sum_q + {{(ACC_W-PW){1'b0}}, abs_s};
      count_d   = count_q + {{(ACC_W-1){1'b0}}, 1'b1};
      if (exact_s > max_exact_q) begin
        max_exact_d = exact_s;
      end else begin
        max_exact_d = max_exact_q;
      end
    end else begin
      err_sum_d = err_sum_q;
    end
  end

  // State registers; async reset returns every output to zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q  <= 1'b0;
      prod_exact_q <= {PW{1'b0}};
      prod_hlr_q   <= {PW{1'b0}};
      abs_err_q    <= {PW{1'b0}};
      err_sum_q    <= {ACC_W{1'b0}};
      max_exact_q  <= {PW{1'b0}};
      count_q      <= {ACC_W{1'b0}};
    end else begin
      out_valid_q  <= out_valid_d;
      prod_exact_q <= prod_exact_d;
      prod_hlr_q   <= prod_hlr_d;
      abs_err_q    <= abs_err_d;
      err_sum_q    <= err_sum_d;
      max_exact_q  <= max_exact_d;
      count_q      <= count_d;
    end
  end

  assign out_valid    = out_valid_q;
  assign prod_exact   = prod_exact_q;
  assign prod_hlr     = prod_hlr_q;
  assign abs_err      = abs_err_q;
  assign err_sum      = err_sum_q;
  assign max_exact    = max_exact_q;
  assign sample_count = count_q;

  hlr_bm1_err_monitor_chk #(.PW(PW)) u_chk (
    .clk       (clk),
    .rst       (rst),
    .abs_err   (abs_err_q),
    .max_exact (max_exact_q)
  );

endmodule

// Invariants: the digit rounding never errs by more than 2*|x|, and the
// maximum starts at zero so it can never go negative.
module hlr_bm1_err_monitor_chk #(
  parameter int PW = 16
) (
  input logic                 clk,
  input logic                 rst,
  input logic [PW-1:0]        abs_err,
  input logic signed [PW-1:0] max_exact
);

  a_err_bound: assert property (@(posedge clk) disable iff (rst) abs_err <= 16'd256);
  a_max_nonneg: assert property (@(posedge clk) disable iff (rst) !max_exact[PW-1]);

endmodule

// File: tb/tb_hlr_bm1_err_monitor.sv
// Table vectors, hand sequences and an exhaustive sweep, all checked through a
// scoreboard queue that is filled at drive time and drained on out_valid.

module tb_hlr_bm1_err_monitor;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               in_valid = 1'b0;
  logic               clear = 1'b0;
  logic signed [7:0]  x = 8'sd0;
  logic signed [7:0]  y = 8'sd0;
  logic               out_valid;
  logic signed [15:0] prod_exact;
  logic signed [15:0] prod_hlr;
  logic [15:0]        abs_err;
  logic [31:0]        err_sum;
  logic signed [15:0] max_exact;
  logic [31:0]        sample_count;

  always #5 clk = ~clk;

  hlr_bm1_err_monitor #(.WIDTH(8), .ACC_W(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .clear        (clear),
    .x            (x),
    .y            (y),
    .out_valid    (out_valid),
    .prod_exact   (prod_exact),
    .prod_hlr     (prod_hlr),
    .abs_err      (abs_err),
    .err_sum      (err_sum),
    .max_exact    (max_exact),
    .sample_count (sample_count)
  );

  typedef struct {
    logic signed [7:0]  xv;
    logic signed [7:0]  yv;
    logic signed [15:0] ex;
    logic signed [15:0] hl;
    logic [15:0]        ae;
  } vec_t;

  typedef struct {
    logic signed [15:0] ex;
    logic signed [15:0] hl;
    logic [15:0]        ae;
    logic [31:0]        es;
    logic [31:0]        cnt;
    logic signed [15:0] mx;
  } exp_t;

  exp_t               sb_q[$];
  exp_t               mon_r;
  vec_t               tbl[10];
  int                 total = 0;
  int                 bad = 0;
  logic [31:0]        m_es = 32'd0;
  logic [31:0]        m_cnt = 32'd0;
  logic signed [15:0] m_mx = 16'sd0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  // Integer reference: rebuild y_approx from the digit formulas and multiply.
  function automatic void hlr_model(input logic signed [7:0] xv, input logic signed [7:0] yv,
                                    output logic signed [15:0] ex, output logic signed [15:0] hl,
                                    output logic [15:0] ae);
    logic signed [3:0] nib;
    int xi, yi, d0, m, am, a0, d1, d2, ya, di;
    xi  = int'(xv);
    yi  = int'(yv);
    nib = yv[3:0];
    d0  = int'(nib);
    m   = (d0 < 0) ? -d0 : d0;
    am  = (m == 3 || m == 5) ? 4 : ((m >= 6) ? 8 : m);
    a0  = (d0 < 0) ? -am : am;
    d1  = -2 * int'(yv[5]) + int'(yv[4]) + int'(yv[3]);
    d2  = -2 * int'(yv[7]) + int'(yv[6]) + int'(yv[5]);
    ya  = a0 + 16 * d1 + 64 * d2;
    ex  = 16'(xi * yi);
    hl  = 16'(xi * ya);
    di  = int'(hl) - int'(ex);
    ae  = 16'((di < 0) ? -di : di);
  endfunction

  task automatic send(input logic signed [7:0] xv, input logic signed [7:0] yv,
                      input logic signed [15:0] ex, input logic signed [15:0] hl,
                      input logic [15:0] ae, input logic clr);
    exp_t r;
    @(posedge clk);
    #1;
    x = xv;
    y = yv;
    in_valid = 1'b1;
    clear = clr;
    if (clr) begin
      m_es = 32'd0;
      m_cnt = 32'd0;
      m_mx = 16'sd0;
    end else begin
      m_es = m_es + {16'd0, ae};
      m_cnt = m_cnt + 32'd1;
      if (ex > m_mx) m_mx = ex;
    end
    r.ex = ex; r.hl = hl; r.ae = ae; r.es = m_es; r.cnt = m_cnt; r.mx = m_mx;
    sb_q.push_back(r);
  endtask

  task automatic idle();
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    clear = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 10 && sb_q.size() != 0; i++) @(negedge clk);
    check("scoreboard_drain", sb_q.size(), 32'd0);
  endtask

  task automatic do_clear();
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    clear = 1'b1;
    m_es = 32'd0;
    m_cnt = 32'd0;
    m_mx = 16'sd0;
    @(posedge clk);
    #1;
    clear = 1'b0;
    @(negedge clk);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_out_valid"}, {31'd0, out_valid}, 32'd0);
    check({tag, "_prod_exact"}, prod_exact, 16'sd0);
    check({tag, "_prod_hlr"}, prod_hlr, 16'sd0);
    check({tag, "_abs_err"}, abs_err, 16'd0);
    check({tag, "_err_sum"}, err_sum, 32'd0);
    check({tag, "_max_exact"}, max_exact, 16'sd0);
    check({tag, "_sample_count"}, sample_count, 32'd0);
  endtask

  always @(negedge clk) begin
    if (!rst && out_valid) begin
      if (sb_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_out_valid: got out_valid=1, want no pending sample");
      end else begin
        mon_r = sb_q.pop_front();
        check("prod_exact", prod_exact, mon_r.ex);
        check("prod_hlr", prod_hlr, mon_r.hl);
        check("abs_err", abs_err, mon_r.ae);
        check("err_sum", err_sum, mon_r.es);
        check("sample_count", sample_count, mon_r.cnt);
        check("max_exact", max_exact, mon_r.mx);
      end
    end
  end

  initial begin
    logic signed [15:0] mex, mhl;
    logic [15:0]        mae;
    real                nmed;

    tbl[0] = '{8'sd5,    8'sd3,    16'sd15,    16'sd20,     16'd5};
    tbl[1] = '{8'sd10,   8'sd6,    16'sd60,    16'sd80,     16'd20};
    tbl[2] = '{8'sd0,    -8'sd77,  16'sd0,     16'sd0,      16'd0};
    tbl[3] = '{8'sd2,    8'sd13,   16'sd26,    16'sd24,     16'd2};
    tbl[4] = '{8'sh80,   8'sh80,   16'sd16384, 16'sd16384,  16'd0};
    tbl[5] = '{8'sd7,    -8'sd1,   -16'sd7,    -16'sd7,     16'd0};
    tbl[6] = '{-8'sd3,   8'sd7,    -16'sd21,   -16'sd24,    16'd3};
    tbl[7] = '{8'sd127,  8'sd127,  16'sd16129, 16'sd16129,  16'd0};
    tbl[8] = '{8'sh80,   8'sd5,    -16'sd640,  -16'sd512,   16'd128};
    tbl[9] = '{8'sh80,   8'sd6,    -16'sd768,  -16'sd1024,  16'd256};

    repeat (3) @(posedge clk);
    #2;
    rst = 1'b0;
    @(negedge clk);
    check_all_zero("reset");

    for (int i = 0; i < 10; i++) begin
      send(tbl[i].xv, tbl[i].yv, tbl[i].ex, tbl[i].hl, tbl[i].ae, 1'b0);
    end
    idle();
    drain();

    // Outputs hold and out_valid drops while in_valid is low.
    @(negedge clk);
    check("idle_out_valid", {31'd0, out_valid}, 32'd0);
    check("hold_prod_exact", prod_exact, -16'sd768);
    check("hold_abs_err", abs_err, 16'd256);
    check("table_max_exact", max_exact, 16'sd16384);

    // Clear together with a sample: stats zero, sample still loads.
    send(8'sd5, 8'sd3, 16'sd15, 16'sd20, 16'd5, 1'b1);
    send(8'sd10, 8'sd6, 16'sd60, 16'sd80, 16'd20, 1'b0);
    idle();
    drain();

    // Reset between edges clears outputs without a clock edge.
    send(8'sh80, 8'sh80, 16'sd16384, 16'sd16384, 16'd0, 1'b0);
    idle();
    drain();
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check_all_zero("async_reset");
    sb_q.delete();
    m_es = 32'd0;
    m_cnt = 32'd0;
    m_mx = 16'sd0;
    #10;
    rst = 1'b0;

    do_clear();
    for (int xi = -128; xi < 128; xi++) begin
      for (int yi = -128; yi < 128; yi++) begin
        hlr_model(8'(xi), 8'(yi), mex, mhl, mae);
        send(8'(xi), 8'(yi), mex, mhl, mae, 1'b0);
      end
    end
    idle();
    drain();
    @(negedge clk);
    check("sweep_count", sample_count, 32'd65536);
    check("sweep_max", max_exact, 16'sd16384);
    check("sweep_err_sum", err_sum, m_es);
    nmed = real'(err_sum) / 65536.0 / 16384.0;
    $display("sweep NMED = %e (err_sum=%0d)", nmed, err_sum);

    do_clear();
    check("clear_err_sum", err_sum, 32'd0);
    check("clear_count", sample_count, 32'd0);
    check("clear_max", max_exact, 16'sd0);

    send(8'sd10, 8'sd6, 16'sd60, 16'sd80, 16'd20, 1'b0);
    idle();
    drain();
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check_all_zero("final_reset");
    #10;
    rst = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
